// File: rtl/cache_txn_sequencer.sv
// Cache transaction sequencer: accepts one CPU or snoop command at a time,
// looks up the addressed line, optionally writes back the victim, issues at
// most one further bus operation and reports the resulting line-state update.
module cache_txn_sequencer #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [3:0]        cmd,
    input  logic [ADDR_W-1:0] addr,
    input  logic              hit,
    input  logic [1:0]        hit_state,
    input  logic [1:0]        victim_state,
    input  logic [ADDR_W-1:0] victim_addr,
    output logic              bus_req,
    output logic [2:0]        bus_op,
    output logic [ADDR_W-1:0] bus_addr,
    input  logic              bus_gnt,
    input  logic [1:0]        snp_rslt,
    output logic              upd_valid,
    output logic [1:0]        upd_state,
    output logic              upd_victim,
    output logic              clr_pulse,
    output logic              done,
    output logic              cmd_err
);

    localparam logic [1:0] ST_M = 2'd0;
    localparam logic [1:0] ST_E = 2'd1;
    localparam logic [1:0] ST_S = 2'd2;
    localparam logic [1:0] ST_I = 2'd3;

    localparam logic [2:0] OP_READ  = 3'd0;
    localparam logic [2:0] OP_WRITE = 3'd1;
    localparam logic [2:0] OP_INV   = 3'd2;
    localparam logic [2:0] OP_RWIM  = 3'd3;

    localparam logic [1:0] SNP_NO_HIT = 2'd0;

    localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(6'h3f);

    typedef enum logic [2:0] {IDLE, LOOKUP, WB, BUS, FIN} state_t;

    state_t state, state_nxt, look_nxt;

    logic [3:0]        cmd_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] wb_addr_q;
    logic [2:0]        bus_op_q;
    logic              gap_q;
    logic              upd_q;
    logic [1:0]        upd_state_q;
    logic              upd_victim_q;
    logic              fill_q;
    logic              clr_q;
    logic              err_q;

    logic              present;
    logic              wb_need;
    logic [2:0]        d_op;
    logic              d_upd;
    logic [1:0]        d_ust;
    logic              d_uvic;
    logic              d_fill;
    logic              d_clr;
    logic              d_err;

    // Registers the accepted command and, at the end of LOOKUP, everything the
    // later phases need, so the array and victim inputs are only trusted for
    // that one cycle. gap_q holds bus_req low for the cycle after a writeback
    // grant; a read fill takes its final state from the snoop result seen with
    // the grant of its READ.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cmd_q        <= '0;
            addr_q       <= '0;
            wb_addr_q    <= '0;
            bus_op_q     <= '0;
            gap_q        <= 1'b0;
            upd_q        <= 1'b0;
            upd_state_q  <= '0;
            upd_victim_q <= 1'b0;
            fill_q       <= 1'b0;
            clr_q        <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        cmd_q  <= cmd;
                        addr_q <= addr & LINE_MASK;
                    end
                end
                LOOKUP: begin
                    wb_addr_q    <= victim_addr & LINE_MASK;
                    bus_op_q     <= d_op;
                    gap_q        <= 1'b0;
                    upd_q        <= d_upd;
                    upd_state_q  <= d_ust;
                    upd_victim_q <= d_uvic;
                    fill_q       <= d_fill;
                    clr_q        <= d_clr;
                    err_q        <= d_err;
                end
                WB: begin
                    if (bus_gnt) begin
                        gap_q <= 1'b1;
                    end
                end
                BUS: begin
                    gap_q <= 1'b0;
                    if (!gap_q && bus_gnt && fill_q) begin
                        upd_state_q <= (snp_rslt == SNP_NO_HIT) ? ST_E : ST_S;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Decides what the looked-up command needs (writeback, bus op, update),
    // steps the state machine and drives the outputs, which depend only on the
    // current state and the registered decisions.
    always_comb begin
        state_nxt  = state;
        look_nxt   = FIN;
        d_op       = OP_READ;
        d_upd      = 1'b0;
        d_ust      = ST_M;
        d_uvic     = 1'b0;
        d_fill     = 1'b0;
        d_clr      = 1'b0;
        d_err      = 1'b0;
        present    = hit && (hit_state != ST_I);
        wb_need    = (victim_state == ST_M);
        cmd_ready  = 1'b0;
        bus_req    = 1'b0;
        bus_op     = '0;
        bus_addr   = '0;
        upd_valid  = 1'b0;
        upd_state  = '0;
        upd_victim = 1'b0;
        clr_pulse  = 1'b0;
        done       = 1'b0;
        cmd_err    = 1'b0;

        case (cmd_q)
            4'd0, 4'd2: begin
                if (!present) begin
                    d_op     = OP_READ;
                    d_upd    = 1'b1;
                    d_uvic   = 1'b1;
                    d_fill   = 1'b1;
                    d_ust    = ST_E;
                    look_nxt = wb_need ? WB : BUS;
                end
            end
            4'd1: begin
                d_upd = 1'b1;
                if (!present) begin
                    d_op     = OP_RWIM;
                    d_uvic   = 1'b1;
                    look_nxt = wb_need ? WB : BUS;
                end else if (hit_state == ST_S) begin
                    d_op     = OP_INV;
                    look_nxt = BUS;
                end
            end
            4'd3: begin
                if (present) begin
                    d_upd = 1'b1;
                    d_ust = ST_I;
                end
            end
            4'd4, 4'd6: begin
                if (present) begin
                    d_upd = 1'b1;
                    d_ust = (cmd_q == 4'd4) ? ST_S : ST_I;
                    if (hit_state == ST_M) begin
                        d_op     = OP_WRITE;
                        look_nxt = BUS;
                    end
                end
            end
            4'd5, 4'd9: begin
            end
            4'd8: d_clr = 1'b1;
            default: d_err = 1'b1;
        endcase

        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) state_nxt = LOOKUP;
            end
            LOOKUP: state_nxt = look_nxt;
            WB: begin
                bus_req  = 1'b1;
                bus_op   = OP_WRITE;
                bus_addr = wb_addr_q;
                if (bus_gnt) state_nxt = BUS;
            end
            BUS: begin
                if (!gap_q) begin
                    bus_req  = 1'b1;
                    bus_op   = bus_op_q;
                    bus_addr = addr_q;
                    if (bus_gnt) state_nxt = FIN;
                end
            end
            FIN: begin
                done       = 1'b1;
                upd_valid  = upd_q;
                upd_state  = upd_q ? upd_state_q : 2'd0;
                upd_victim = upd_q && upd_victim_q;
                clr_pulse  = clr_q;
                cmd_err    = err_q;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_cache_txn_sequencer.sv
// Self-checking bench for cache_txn_sequencer: directed cases for the
// interesting protocol corners followed by randomized commands, each checked
// against a transaction-level model of the coherence rules.
module tb_cache_txn_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd;
    logic [31:0] addr;
    logic        hit;
    logic [1:0]  hit_state;
    logic [1:0]  victim_state;
    logic [31:0] victim_addr;
    logic        bus_req;
    logic [2:0]  bus_op;
    logic [31:0] bus_addr;
    logic        bus_gnt;
    logic [1:0]  snp_rslt;
    logic        upd_valid;
    logic [1:0]  upd_state;
    logic        upd_victim;
    logic        clr_pulse;
    logic        done;
    logic        cmd_err;

    int compared   = 0;
    int mismatched = 0;

    typedef struct packed {
        logic [1:0]  nops;
        logic [2:0]  op0;
        logic [31:0] ad0;
        logic [2:0]  op1;
        logic [31:0] ad1;
        logic        uv;
        logic [1:0]  us;
        logic        uvic;
        logic        clr;
        logic        err;
    } exp_t;

    cache_txn_sequencer #(.ADDR_W(32)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd(cmd), .addr(addr), .hit(hit), .hit_state(hit_state),
        .victim_state(victim_state), .victim_addr(victim_addr),
        .bus_req(bus_req), .bus_op(bus_op), .bus_addr(bus_addr),
        .bus_gnt(bus_gnt), .snp_rslt(snp_rslt), .upd_valid(upd_valid),
        .upd_state(upd_state), .upd_victim(upd_victim),
        .clr_pulse(clr_pulse), .done(done), .cmd_err(cmd_err)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        if (obs !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t add_op(input exp_t e, input logic [2:0] op, input logic [31:0] ad);
        exp_t r = e;
        if (r.nops == 2'd0) begin
            r.op0 = op;
            r.ad0 = ad;
        end else begin
            r.op1 = op;
            r.ad1 = ad;
        end
        r.nops = r.nops + 2'd1;
        return r;
    endfunction

    // Transaction-level model: the list of bus operations a command causes and
    // the final line update, straight from the MESI handling rules.
    function automatic exp_t model(input int c, input logic h, input logic [1:0] hs,
                                   input logic [1:0] vs, input logic [31:0] a,
                                   input logic [31:0] va, input logic [1:0] sn);
        exp_t e = '0;
        logic [31:0] line  = {a[31:6], 6'd0};
        logic [31:0] vline = {va[31:6], 6'd0};
        logic present = h && (hs != 2'd3);
        case (c)
            0, 2: if (!present) begin
                if (vs == 2'd0) e = add_op(e, 3'd1, vline);
                e = add_op(e, 3'd0, line);
                e.uv = 1'b1; e.uvic = 1'b1;
                e.us = (sn == 2'd0) ? 2'd1 : 2'd2;
            end
            1: begin
                e.uv = 1'b1; e.us = 2'd0;
                if (!present) begin
                    if (vs == 2'd0) e = add_op(e, 3'd1, vline);
                    e = add_op(e, 3'd3, line);
                    e.uvic = 1'b1;
                end else if (hs == 2'd2) begin
                    e = add_op(e, 3'd2, line);
                end
            end
            3: if (present) begin e.uv = 1'b1; e.us = 2'd3; end
            4, 6: if (present) begin
                if (hs == 2'd0) e = add_op(e, 3'd1, line);
                e.uv = 1'b1;
                e.us = (c == 4) ? 2'd2 : 2'd3;
            end
            5, 9: ;
            8: e.clr = 1'b1;
            default: e.err = 1'b1;
        endcase
        return e;
    endfunction

    task automatic randomize_lookup();
        hit          = 1'($urandom);
        hit_state    = 2'($urandom);
        victim_state = 2'($urandom);
        victim_addr  = $urandom;
    endtask

    // Runs one command end to end: presents the lookup result only during the
    // LOOKUP cycle, answers bus requests after a random delay (plus stray
    // grants while idle), then compares what was observed with the model.
    task automatic applyStimulus(input string name, input int c, input logic [31:0] a,
                                 input logic h, input logic [1:0] hs, input logic [1:0] vs,
                                 input logic [31:0] va, input logic [1:0] sn,
                                 input int gmin, input int gmax);
        exp_t e;
        logic [2:0]  oop [2];
        logic [31:0] oad [2];
        int ops = 0, cyc = 1, done_cyc = -1, stray = 0, wait_cnt;
        logic prev_gnt = 1'b0;
        logic ouv = 1'b0, ouvic = 1'b0, oclr = 1'b0, oerr = 1'b0;
        logic [1:0] ous = 2'd0;
        oop[0] = '0; oop[1] = '0; oad[0] = '0; oad[1] = '0;
        e = model(c, h, hs, vs, a, va, sn);
        checkOutput({name, "/ready"}, 64'(cmd_ready), 64'd1);
        cmd_valid = 1'b1;
        cmd = 4'(c);
        addr = a;
        randomize_lookup();
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd = 4'($urandom);
        addr = $urandom;
        wait_cnt = $urandom_range(gmax, gmin);
        for (int k = 0; k < 60 && done_cyc < 0; k++) begin
            if (cyc == 1) begin
                hit = h; hit_state = hs; victim_state = vs; victim_addr = va;
            end else begin
                randomize_lookup();
            end
            if (prev_gnt) checkOutput({name, "/req_drop"}, 64'(bus_req), 64'd0);
            bus_gnt = 1'b0;
            snp_rslt = 2'($urandom);
            if (bus_req) begin
                if (wait_cnt == 0) begin
                    bus_gnt = 1'b1;
                    snp_rslt = sn;
                    if (ops < 2) begin
                        oop[ops] = bus_op;
                        oad[ops] = bus_addr;
                    end
                    ops++;
                    wait_cnt = $urandom_range(gmax, gmin);
                end else begin
                    wait_cnt--;
                end
            end else if ($urandom_range(3, 0) == 0) begin
                bus_gnt = 1'b1;
            end
            if (done) begin
                done_cyc = cyc;
                ouv = upd_valid; ous = upd_state; ouvic = upd_victim;
                oclr = clr_pulse; oerr = cmd_err;
            end else if (upd_valid || clr_pulse || cmd_err) begin
                stray++;
            end
            prev_gnt = bus_gnt && bus_req;
            @(posedge clk); #1;
            cyc++;
        end
        bus_gnt = 1'b0;
        checkOutput({name, "/done_seen"}, 64'(done_cyc >= 0), 64'd1);
        checkOutput({name, "/done_drop"}, 64'(done), 64'd0);
        checkOutput({name, "/ready_back"}, 64'(cmd_ready), 64'd1);
        checkOutput({name, "/nops"}, 64'(ops), 64'(e.nops));
        if (e.nops >= 2'd1) checkOutput({name, "/op0"}, {29'd0, oop[0], oad[0]}, {29'd0, e.op0, e.ad0});
        if (e.nops == 2'd2) checkOutput({name, "/op1"}, {29'd0, oop[1], oad[1]}, {29'd0, e.op1, e.ad1});
        if (e.nops == 2'd0) checkOutput({name, "/latency"}, 64'(done_cyc), 64'd2);
        checkOutput({name, "/upd_valid"}, 64'(ouv), 64'(e.uv));
        if (e.uv) checkOutput({name, "/upd"}, {62'd0, ous, ouvic} >> 1 | 64'(ouvic) << 8,
                              {62'd0, e.us, e.uvic} >> 1 | 64'(e.uvic) << 8);
        checkOutput({name, "/clr_err"}, {62'd0, oclr, oerr}, {62'd0, e.clr, e.err});
        checkOutput({name, "/stray_pulse"}, 64'(stray), 64'd0);
    endtask

    // Reset while a request waits for its grant: the request must vanish on
    // the next cycle with no update, and the block must work normally after.
    task automatic reset_mid_request();
        int n = 0;
        cmd_valid = 1'b1; cmd = 4'd1; addr = 32'h5555_1234;
        hit = 1'b0; hit_state = 2'd3; victim_state = 2'd3; victim_addr = 32'h0;
        bus_gnt = 1'b0;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        while (!bus_req && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("rst_mid/req_seen", 64'(bus_req), 64'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        checkOutput("rst_mid/req_gone", 64'(bus_req), 64'd0);
        checkOutput("rst_mid/no_upd", {62'd0, upd_valid, done}, 64'd0);
        rst = 1'b0;
        applyStimulus("rst_mid/after", 0, 32'h0000_2040, 1'b1, 2'd1, 2'd3, 32'h0, 2'd0, 0, 2);
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd = '0; addr = '0; hit = 1'b0;
        hit_state = '0; victim_state = '0; victim_addr = '0; bus_gnt = 1'b0; snp_rslt = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset/ready", 64'(cmd_ready), 64'd1);
        checkOutput("reset/bus", {27'd0, bus_req, bus_op, bus_addr}, 64'd0);
        checkOutput("reset/pulses", {58'd0, upd_valid, upd_state, upd_victim, clr_pulse, done, cmd_err} >> 0, 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        applyStimulus("rd_miss_vI",  0, 32'h1234_5678, 1'b0, 2'd3, 2'd3, 32'h0, 2'd0, 3, 3);
        applyStimulus("wr_miss_vM",  1, 32'h0000_10C4, 1'b0, 2'd3, 2'd0, 32'hABCD_0000, 2'd0, 0, 2);
        applyStimulus("wr_hit_S",    1, 32'h0000_3003, 1'b1, 2'd2, 2'd3, 32'h0, 2'd0, 1, 2);
        applyStimulus("wr_hit_E",    1, 32'h0000_4000, 1'b1, 2'd1, 2'd0, 32'h7, 2'd0, 0, 1);
        applyStimulus("rdx_hit_M",   6, 32'h0000_5080, 1'b1, 2'd0, 2'd0, 32'h9, 2'd1, 0, 2);
        applyStimulus("snpwr_hit_M", 5, 32'h0000_6000, 1'b1, 2'd0, 2'd0, 32'h9, 2'd1, 0, 2);
        applyStimulus("rd_miss_vM",  2, 32'h0BAD_F00D, 1'b0, 2'd0, 2'd0, 32'h7777_0040, 2'd2, 0, 3);
        applyStimulus("snprd_hit_M", 4, 32'h0000_7050, 1'b1, 2'd0, 2'd1, 32'h0, 2'd0, 0, 1);
        applyStimulus("clear",       8, 32'h0, 1'b1, 2'd0, 2'd0, 32'h0, 2'd0, 0, 1);
        applyStimulus("print",       9, 32'h0, 1'b1, 2'd0, 2'd0, 32'h0, 2'd0, 0, 1);
        applyStimulus("bad_cmd12",  12, 32'h0, 1'b1, 2'd0, 2'd0, 32'h0, 2'd0, 0, 1);
        reset_mid_request();

        for (int i = 0; i < 200; i++) begin
            applyStimulus($sformatf("rand%0d", i), int'($urandom_range(15, 0)), $urandom,
                          1'($urandom), 2'($urandom), 2'($urandom), $urandom,
                          2'($urandom_range(2, 0)), 0, 3);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
